// File: rtl/axi_lite_test_regs.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit read/write registers with byte strobes,
// OKAY/SLVERR responses, and per-register write pulses towards the core logic.
module axi_lite_test_regs #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int         IDXW        = ADDR_WIDTH - 2;
  localparam int         NBYTES      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [IDXW-1:0]                      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
  logic [NBYTES-1:0]                    wstrb_q, wstrb_d;
  logic                                 bvalid_q, bvalid_d;
  logic [1:0]                           bresp_q, bresp_d;
  logic [NUM_REGS-1:0]                  reg_wr_q, reg_wr_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic                                 rvalid_q, rvalid_d;
  logic [1:0]                           rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;

  logic                  aw_hs, w_hs;
  logic                  commit;
  logic                  w_hit;
  logic [IDXW-1:0]       c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [NBYTES-1:0]     c_strb;
  logic [IDXW-1:0]       r_idx;

  logic unused_inputs;
  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_DATA);
  assign WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_ADDR);
  assign ARREADY = (rstate_q == R_IDLE);
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign reg_q   = regs_q;
  assign reg_wr  = reg_wr_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign r_idx = ARADDR[ADDR_WIDTH-1:2];

  // Write channel: address and data may arrive in either order; the completing
  // handshake takes its half straight from the bus and the other from the latch.
  always_comb begin
    wstate_d = wstate_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    reg_wr_d = '0;
    commit   = 1'b0;
    w_hit    = 1'b0;
    c_idx    = awidx_q;
    c_data   = wdata_q;
    c_strb   = wstrb_q;

    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = AWADDR[ADDR_WIDTH-1:2];
          c_data = WDATA;
          c_strb = WSTRB;
        end else if (aw_hs) begin
          awidx_d  = AWADDR[ADDR_WIDTH-1:2];
          wstate_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          wstate_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = WDATA;
          c_strb = WSTRB;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = AWADDR[ADDR_WIDTH-1:2];
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (c_idx == IDXW'(i)) begin
          w_hit       = 1'b1;
          reg_wr_d[i] = 1'b1;
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (c_strb[b]) begin
              regs_d[i][8*b +: 8] = c_data[8*b +: 8];
            end
          end
        end
      end
      bresp_d  = w_hit ? RESP_OKAY : RESP_SLVERR;
      bvalid_d = 1'b1;
      wstate_d = W_RESP;
    end
  end

  // Read channel samples regs_q, so a same-edge write is not visible yet.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;

    case (rstate_q)
      R_IDLE: begin
        if (ARVALID) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDXW'(i)) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          rvalid_d = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      reg_wr_q <= '0;
      regs_q   <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      awidx_q  <= awidx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      reg_wr_q <= reg_wr_d;
      regs_q   <= regs_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_test_regs.sv
// Bench for axi_lite_test_regs: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model of the register file.
module tb_axi_lite_test_regs;

  localparam int AW = 5;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              ARESET;
  logic [AW-1:0]     AWADDR, ARADDR;
  logic [2:0]        AWPROT, ARPROT;
  logic              AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic              AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [31:0]       WDATA, RDATA;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP, RRESP;
  logic [32*NR-1:0]  reg_q;
  logic [NR-1:0]     reg_wr;

  always #5 clk = ~clk;

  axi_lite_test_regs #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .ACLK   (clk),
    .ARESET (ARESET),
    .AWADDR (AWADDR),
    .AWPROT (AWPROT),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARPROT (ARPROT),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out waiting for handshake", name);
  endtask

  // Transaction-level model: pending address/data flags, outstanding responses, register array.
  logic [31:0] m_regs [NR];
  logic        m_have_aw, m_have_w, m_bvalid, m_rvalid;
  int          m_awidx;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_wr;
  logic [1:0]  m_bresp, m_rresp;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_have_aw = 0; m_have_w = 0; m_bvalid = 0; m_rvalid = 0;
    m_awidx = 0; m_wdata = '0; m_wstrb = '0; m_wr = '0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
  endtask

  initial begin : compare_proc
    logic aw_hs, w_hs;
    int   idx;
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("awready", AWREADY, !m_have_aw && !m_bvalid);
      chk("wready",  WREADY,  !m_have_w && !m_bvalid);
      chk("arready", ARREADY, !m_rvalid);
      chk("bvalid",  BVALID,  m_bvalid);
      chk("bresp",   BRESP,   m_bresp);
      chk("rvalid",  RVALID,  m_rvalid);
      chk("rresp",   RRESP,   m_rresp);
      chk("rdata",   RDATA,   m_rdata);
      chk("reg_wr",  reg_wr,  m_wr);
      chk("reg_q",   reg_q,   {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});

      if (ARESET) begin
        model_reset();
      end else begin
        aw_hs = AWVALID && !m_have_aw && !m_bvalid;
        w_hs  = WVALID && !m_have_w && !m_bvalid;
        m_wr  = '0;
        if (m_rvalid) begin
          if (RREADY) m_rvalid = 0;
        end else if (ARVALID) begin
          idx = int'(ARADDR) / 4;
          m_rvalid = 1;
          if (idx < NR) begin
            m_rdata = m_regs[idx];
            m_rresp = 2'b00;
          end else begin
            m_rdata = '0;
            m_rresp = 2'b10;
          end
        end
        if (m_bvalid) begin
          if (BREADY) m_bvalid = 0;
        end else begin
          if (aw_hs) begin
            m_have_aw = 1;
            m_awidx   = int'(AWADDR) / 4;
          end
          if (w_hs) begin
            m_have_w = 1;
            m_wdata  = WDATA;
            m_wstrb  = WSTRB;
          end
          if (m_have_aw && m_have_w) begin
            m_have_aw = 0;
            m_have_w  = 0;
            m_bvalid  = 1;
            if (m_awidx < NR) begin
              for (int b = 0; b < 4; b++)
                if (m_wstrb[b]) m_regs[m_awidx][8*b +: 8] = m_wdata[8*b +: 8];
              m_wr[m_awidx] = 1'b1;
              m_bresp = 2'b00;
            end else begin
              m_bresp = 2'b10;
            end
          end
        end
      end
    end
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] wr);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (AWREADY && WREADY) break;
    end
    if (n == 50) timeout("write_addr");
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0; BREADY = 1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (BVALID) break;
    end
    if (n == 50) timeout("write_resp");
    resp = BRESP;
    wr   = reg_wr;
    @(posedge clk); #1;
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ARREADY) break;
    end
    if (n == 50) timeout("read_addr");
    @(posedge clk); #1;
    ARVALID = 0; RREADY = 1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (RVALID) break;
    end
    if (n == 50) timeout("read_data");
    d    = RDATA;
    resp = RRESP;
    @(posedge clk); #1;
    RREADY = 0;
  endtask

  initial begin : stimulus
    logic [1:0]  resp;
    logic [3:0]  wr;
    logic [31:0] data;

    ARESET = 1; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    WDATA = '0; WSTRB = '0;
    repeat (3) @(posedge clk);
    #1 ARESET = 0;

    @(negedge clk);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_rdata",  RDATA,  32'h0);
    chk("rst_regs",   reg_q,  128'h0);
    chk("rst_ready",  {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge clk); #1;

    // Four full writes then read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(4 * i), 32'(i + 1), 4'hF, resp, wr);
      chk("t1_bresp", resp, 2'b00);
      chk("t1_reg_wr", wr, 4'b0001 << i);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(4 * i), data, resp);
      chk("t1_rdata", data, 32'(i + 1));
      chk("t1_rresp", resp, 2'b00);
    end

    // Address leads data by three cycles
    AWADDR = 5'h04; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    @(negedge clk); chk("t2_awready_c0", AWREADY, 1'b1);
    @(posedge clk); #1 AWVALID = 0;
    @(negedge clk); chk("t2_c1", {AWREADY, WREADY, BVALID}, 3'b010);
    @(posedge clk); #1;
    @(negedge clk); chk("t2_c2", {AWREADY, WREADY, BVALID}, 3'b010);
    @(posedge clk); #1 WVALID = 1;
    @(negedge clk); chk("t2_c3", {AWREADY, WREADY, BVALID}, 3'b010);
    @(posedge clk); #1 WVALID = 0; BREADY = 1;
    @(negedge clk);
    chk("t2_c4_bvalid", BVALID, 1'b1);
    chk("t2_c4_reg_wr", reg_wr, 4'b0010);
    chk("t2_c4_reg1",   reg_q[63:32], 32'hDEADBEEF);
    @(posedge clk); #1 BREADY = 0;
    @(negedge clk); chk("t2_c5_bvalid", BVALID, 1'b0);
    @(posedge clk); #1;

    // Single-byte strobe
    axi_write(5'h00, 32'h00000001, 4'hF, resp, wr);
    axi_write(5'h00, 32'hAABBCCDD, 4'b0010, resp, wr);
    chk("t3_bresp", resp, 2'b00);
    chk("t3_reg_wr", wr, 4'b0001);
    axi_read(5'h00, data, resp);
    chk("t3_rdata", data, 32'h0000CC01);
    chk("t3_model_reg0", m_regs[0], 32'h0000CC01);
    axi_write(5'h04, 32'hFFFFFFFF, 4'b0000, resp, wr);
    chk("t3_nostrb_resp", resp, 2'b00);
    chk("t3_nostrb_wr", wr, 4'b0010);

    // Out of range accesses and ignored low address bits
    axi_write(5'h10, 32'h99, 4'hF, resp, wr);
    chk("t4_bresp", resp, 2'b10);
    chk("t4_reg_wr", wr, 4'b0000);
    axi_read(5'h10, data, resp);
    chk("t4_rdata", data, 32'h0);
    chk("t4_rresp", resp, 2'b10);
    axi_read(5'h1F, data, resp);
    chk("t4_rresp_top", resp, 2'b10);
    axi_write(5'h0B, 32'h33, 4'hF, resp, wr);
    chk("t4_unaligned_wr", wr, 4'b0100);
    chk("t4_regs", reg_q, {32'h4, 32'h33, 32'hDEADBEEF, 32'h0000CC01});

    // Back-pressure on both response channels
    AWADDR = 5'h08; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 5'h04; ARVALID = 1;
    @(negedge clk);
    @(posedge clk); #1 AWVALID = 0; WVALID = 0; ARVALID = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_valids", {BVALID, RVALID}, 2'b11);
      chk("t5_resps",  {BRESP, RRESP}, 4'b0000);
      chk("t5_rdata",  RDATA, 32'hDEADBEEF);
      chk("t5_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
      @(posedge clk); #1;
    end
    BREADY = 1; RREADY = 1;
    @(negedge clk);
    @(posedge clk); #1 BREADY = 0; RREADY = 0;
    @(negedge clk);
    chk("t5_release", {BVALID, RVALID, AWREADY, ARREADY}, 4'b0011);
    @(posedge clk); #1;

    // Reset with a write half-done and a read response pending
    AWADDR = 5'h0C; AWVALID = 1; ARADDR = 5'h00; ARVALID = 1;
    @(negedge clk);
    @(posedge clk); #1 AWVALID = 0; ARVALID = 0; ARESET = 1;
    @(negedge clk);
    chk("t6_pre_rvalid", RVALID, 1'b1);
    chk("t6_pre_awready", {AWREADY, WREADY}, 2'b01);
    @(posedge clk); #1 ARESET = 0;
    @(negedge clk);
    chk("t6_valids", {BVALID, RVALID}, 2'b00);
    chk("t6_regs", reg_q, 128'h0);
    chk("t6_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge clk); #1;
    axi_write(5'h0C, 32'h12345678, 4'hF, resp, wr);
    chk("t6_bresp", resp, 2'b00);
    chk("t6_reg_wr", wr, 4'b1000);
    axi_read(5'h0C, data, resp);
    chk("t6_rdata", data, 32'h12345678);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      AWVALID = 1'($urandom_range(0, 1));
      WVALID  = 1'($urandom_range(0, 1));
      ARVALID = 1'($urandom_range(0, 1));
      BREADY  = ($urandom_range(0, 3) != 0);
      RREADY  = ($urandom_range(0, 3) != 0);
      AWADDR  = AW'($urandom_range(0, 31));
      ARADDR  = AW'($urandom_range(0, 31));
      AWPROT  = 3'($urandom_range(0, 7));
      ARPROT  = 3'($urandom_range(0, 7));
      WDATA   = $urandom;
      WSTRB   = 4'($urandom_range(0, 15));
      ARESET  = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    AWVALID = 0; WVALID = 0; ARVALID = 0; ARESET = 0; BREADY = 1; RREADY = 1;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
